fifo_port_scheduler: RTL

Controller that owns the write and read ports of the BRAM `FIFO_module` in the IPPro datapath. It arbitrates two valid/ready producers onto the single FIFO write port using round-robin. It prefetches FIFO words into a 2-entry output buffer that feeds a valid/ready consumer. It also sequences a flush that drains and discards the FIFO contents.

---
 rtl/fifo_port_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fifo_port_scheduler.sv
// Write/read port controller for the IPPro FIFO_module: round-robin producer arbitration,
// a 2-entry prefetch buffer toward the consumer, and a drain-and-discard flush sequence.
module fifo_port_scheduler #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int OCC_W  = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              flush_i,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              fifo_write_en_o,
    output logic [DATA_W-1:0] fifo_in_o,
    output logic              fifo_read_en_o,
    input  logic [DATA_W-1:0] fifo_out_i,
    input  logic              full_i,
    input  logic              empty_i,
    input  logic              wrerr_i,
    input  logic              rderr_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic              flushing_o,
    output logic              err_o,
    output logic [15:0]       acc_cnt0_o,
    output logic [15:0]       acc_cnt1_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              last_q, last_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic              ret_q, ret_d;
    logic [DATA_W-1:0] obuf_q [2];
    logic [DATA_W-1:0] obuf_d [2];
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       acc0_q, acc0_d;
    logic [15:0]       acc1_q, acc1_d;
    logic              err_q, err_d;

    logic       wr_ok;
    logic       gnt0, gnt1;
    logic       accept0, accept1;
    logic       pop, push, rd_issue, flush_entry;
    logic [2:0] slots;
    logic [1:0] cnt_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush request wins over enable; the flush only ends once nothing is left to read or return.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_i)       state_d = S_FLUSH;
                else if (enable_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (flush_i)        state_d = S_FLUSH;
                else if (!enable_i) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if ((occ_q == '0) && !rd_en_q && !ret_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ok      = (state_q == S_RUN) && (occ_q < OCC_W'(DEPTH)) && !full_i;
        gnt0       = req0_valid_i && (!req1_valid_i || last_q);
        gnt1       = req1_valid_i && (!req0_valid_i || !last_q);
        accept0    = wr_ok && gnt0;
        accept1    = wr_ok && gnt1;
        pop        = (cnt_q != 2'd0) && m_ready_i;
        // Reserve a buffer slot for every word still travelling back from the FIFO.
        slots      = {1'b0, cnt_q} + {2'b00, rd_en_q} + {2'b00, ret_q};
        rd_issue   = 1'b0;
        if (state_q == S_RUN) begin
            rd_issue = enable_i && (occ_q != '0) && !empty_i && (slots < (3'd2 + {2'b00, pop}));
        end else if (state_q == S_FLUSH) begin
            rd_issue = (occ_q != '0) && !empty_i;
        end
        flushing_o = (state_q == S_FLUSH);
    end

    always_comb begin
        occ_d     = occ_q + OCC_W'(accept0 | accept1) - OCC_W'(rd_issue);
        last_d    = accept1 ? 1'b1 : (accept0 ? 1'b0 : last_q);
        wr_en_d   = accept0 | accept1;
        wr_data_d = accept1 ? req1_data_i : (accept0 ? req0_data_i : wr_data_q);
        rd_en_d   = rd_issue;
        ret_d     = rd_en_q;
        acc0_d    = acc0_q + {15'd0, accept0};
        acc1_d    = acc1_q + {15'd0, accept1};
        err_d     = err_q | wrerr_i | rderr_i;

        // Words returning while flushing are dropped; entering flush empties the buffer.
        push        = ret_q && (state_q != S_FLUSH);
        flush_entry = (state_d == S_FLUSH) && (state_q != S_FLUSH);
        obuf_d      = obuf_q;
        cnt_pop     = cnt_q - {1'b0, pop};
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        if (push) begin
            obuf_d[cnt_pop[0]] = fifo_out_i;
        end
        cnt_d = cnt_pop + {1'b0, push};
        if (flush_entry) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q     <= '0;
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            ret_q     <= 1'b0;
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
            cnt_q     <= 2'd0;
            acc0_q    <= 16'd0;
            acc1_q    <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            ret_q     <= ret_d;
            obuf_q    <= obuf_d;
            cnt_q     <= cnt_d;
            acc0_q    <= acc0_d;
            acc1_q    <= acc1_d;
            err_q     <= err_d;
        end
    end

    assign req0_ready_o    = accept0;
    assign req1_ready_o    = accept1;
    assign fifo_write_en_o = wr_en_q;
    assign fifo_in_o       = wr_data_q;
    assign fifo_read_en_o  = rd_en_q;
    assign m_valid_o       = (cnt_q != 2'd0);
    assign m_data_o        = obuf_q[0];
    assign err_o           = err_q;
    assign acc_cnt0_o      = acc0_q;
    assign acc_cnt1_o      = acc1_q;

endmodule
